// File: rtl/clock_pkg.sv
// Shared state codes and default timing for the clock time-set controller.
package clock_pkg;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOUR = 2'd1;
  localparam logic [1:0] ST_MIN  = 2'd2;
  localparam logic [1:0] ST_SEC  = 2'd3;

  localparam int DEF_CNT_W        = 29;
  localparam int DEF_REPEAT_DELAY = 25_000_000;
  localparam int DEF_REPEAT_RATE  = 5_000_000;
  localparam int DEF_TIMEOUT      = 500_000_000;

  // Mode key walks RUN -> HOUR -> MIN -> SEC and the 2-bit code wraps back to RUN.
  function automatic logic [1:0] next_field(input logic [1:0] st);
    return st + 2'd1;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchroniser for an asynchronous key level, plus a registered rising-edge pulse.
// level is delayed one extra flop so it lines up with rise.
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic rise
);

  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_1 <= key;
      sync_2 <= sync_1;
      level  <= sync_2;
      rise   <= sync_2 & ~level;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: mode FSM, hold-to-repeat and idle timeout driving the counter adjust pulses.
//   state   | meaning
//   ST_RUN  | clock counts, keys other than Mode ignored
//   ST_HOUR | hours field selected for adjust
//   ST_MIN  | minutes field selected for adjust
//   ST_SEC  | seconds field selected for adjust
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic       Clk,
  input  logic       Reset_N,
  input  logic       Mode_key,
  input  logic       Up_key,
  input  logic       Down_key,
  input  logic       Tick_1hz,
  output logic       Sec_tick,
  output logic       Sec_add,
  output logic       Sec_sub,
  output logic       Min_add,
  output logic       Min_sub,
  output logic       Hour_add,
  output logic       Hour_sub,
  output logic [1:0] Field_sel,
  output logic       Blink
);

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  logic             mode_level_unused, mode_rise;
  logic             up_level, up_rise, dn_level, dn_rise;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt, to_cnt;
  logic             armed_up, armed_dn, armed_up_nxt, armed_dn_nxt;
  logic             fire_add, fire_sub, rpt_pulse;
  logic             in_set, activity, timeout_hit;

  key_sync_edge u_mode (.clk(Clk), .rst_n(Reset_N), .key(Mode_key), .level(mode_level_unused), .rise(mode_rise));
  key_sync_edge u_up   (.clk(Clk), .rst_n(Reset_N), .key(Up_key),   .level(up_level),          .rise(up_rise));
  key_sync_edge u_down (.clk(Clk), .rst_n(Reset_N), .key(Down_key), .level(dn_level),          .rise(dn_rise));

  assign in_set      = (state != ST_RUN);
  assign activity    = mode_rise | up_rise | dn_rise | rpt_pulse;
  assign timeout_hit = in_set && !activity && (to_cnt == TO_LAST);
  assign Field_sel   = state;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) state <= ST_RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (mode_rise)        state_nxt = next_field(state);
    else if (timeout_hit) state_nxt = ST_RUN;
  end

  // Only the key that produced the first pulse may repeat; both held, a Mode edge or release disarms.
  always_comb begin
    fire_add     = 1'b0;
    fire_sub     = 1'b0;
    rpt_pulse    = 1'b0;
    armed_up_nxt = armed_up;
    armed_dn_nxt = armed_dn;
    rpt_cnt_nxt  = rpt_cnt;
    if (!in_set || mode_rise || (up_level && dn_level)) begin
      armed_up_nxt = 1'b0;
      armed_dn_nxt = 1'b0;
      rpt_cnt_nxt  = '0;
    end else if (up_rise) begin
      fire_add     = 1'b1;
      armed_up_nxt = 1'b1;
      armed_dn_nxt = 1'b0;
      rpt_cnt_nxt  = DELAY_LOAD;
    end else if (dn_rise) begin
      fire_sub     = 1'b1;
      armed_up_nxt = 1'b0;
      armed_dn_nxt = 1'b1;
      rpt_cnt_nxt  = DELAY_LOAD;
    end else if ((armed_up && up_level) || (armed_dn && dn_level)) begin
      if (rpt_cnt == '0) begin
        rpt_pulse   = 1'b1;
        fire_add    = armed_up;
        fire_sub    = armed_dn;
        rpt_cnt_nxt = RATE_LOAD;
      end else begin
        rpt_cnt_nxt = rpt_cnt - 1'b1;
      end
    end else begin
      armed_up_nxt = 1'b0;
      armed_dn_nxt = 1'b0;
      rpt_cnt_nxt  = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      rpt_cnt  <= '0;
      armed_up <= 1'b0;
      armed_dn <= 1'b0;
      to_cnt   <= '0;
      Sec_tick <= 1'b0;
      Sec_add  <= 1'b0;
      Sec_sub  <= 1'b0;
      Min_add  <= 1'b0;
      Min_sub  <= 1'b0;
      Hour_add <= 1'b0;
      Hour_sub <= 1'b0;
      Blink    <= 1'b0;
    end else begin
      rpt_cnt  <= rpt_cnt_nxt;
      armed_up <= armed_up_nxt;
      armed_dn <= armed_dn_nxt;
      to_cnt   <= (!in_set || activity) ? '0 : to_cnt + 1'b1;
      Sec_tick <= !in_set && Tick_1hz;
      Sec_add  <= fire_add && (state == ST_SEC);
      Sec_sub  <= fire_sub && (state == ST_SEC);
      Min_add  <= fire_add && (state == ST_MIN);
      Min_sub  <= fire_sub && (state == ST_MIN);
      Hour_add <= fire_add && (state == ST_HOUR);
      Hour_sub <= fire_sub && (state == ST_HOUR);
      if (!in_set || (state_nxt != state)) Blink <= 1'b0;
      else if (Tick_1hz)                   Blink <= ~Blink;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expected pulses, a monitor pops and compares.
module tb_clock_set_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_N, Mode_key, Up_key, Down_key, Tick_1hz;
  logic       Sec_tick, Sec_add, Sec_sub, Min_add, Min_sub, Hour_add, Hour_sub, Blink;
  logic [1:0] Field_sel;

  typedef struct {
    int         cyc;
    logic [5:0] code;
  } ev_t;

  // adjust vector order: {Sec_add, Sec_sub, Min_add, Min_sub, Hour_add, Hour_sub}
  localparam logic [5:0] A_SADD = 6'b100000;
  localparam logic [5:0] A_SSUB = 6'b010000;
  localparam logic [5:0] A_MSUB = 6'b000100;
  localparam logic [5:0] A_HADD = 6'b000010;

  ev_t  adj_q[$];
  int   tick_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   tick_en = 0;
  bit   exp_run = 0;
  logic [5:0] adj;

  clock_set_ctrl #(.CNT_W(29), .REPEAT_DELAY(8), .REPEAT_RATE(4), .TIMEOUT(100)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .Mode_key(Mode_key), .Up_key(Up_key), .Down_key(Down_key),
    .Tick_1hz(Tick_1hz), .Sec_tick(Sec_tick), .Sec_add(Sec_add), .Sec_sub(Sec_sub),
    .Min_add(Min_add), .Min_sub(Min_sub), .Hour_add(Hour_add), .Hour_sub(Hour_sub),
    .Field_sel(Field_sel), .Blink(Blink)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  assign adj = {Sec_add, Sec_sub, Min_add, Min_sub, Hour_add, Hour_sub};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_adj(input int c, input logic [5:0] code);
    ev_t e;
    e.cyc  = c;
    e.code = code;
    adj_q.push_back(e);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge Clk);
  endtask

  task automatic mode_pulse();
    Mode_key = 1'b1;
    @(negedge Clk);
    Mode_key = 1'b0;
  endtask

  // 1 Hz tick source: driven just after the rising edge so it never races the stimulus.
  initial begin
    Tick_1hz = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      Tick_1hz = tick_en && (cyc % 10 == 0);
      if (Tick_1hz && exp_run) tick_q.push_back(cyc + 1);
    end
  end

  always @(negedge Clk) begin
    if (Sec_tick) begin
      if (tick_q.size() == 0) check("sec_tick_unexpected", 1, 0);
      else check("sec_tick_cycle", cyc, tick_q.pop_front());
    end
    if (adj != 6'b0) begin
      if (adj_q.size() == 0) begin
        check("adjust_unexpected", {26'b0, adj}, 0);
      end else begin
        ev_t e;
        e = adj_q.pop_front();
        check("adjust_code", {26'b0, adj}, {26'b0, e.code});
        check("adjust_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset_N = 1'b0; Mode_key = 1'b0; Up_key = 1'b0; Down_key = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_field", Field_sel, 0);
    check("reset_outs", {Sec_tick, adj, Blink}, 0);
    Reset_N = 1'b1;
    exp_run = 1; tick_en = 1;
    repeat (35) @(negedge Clk);
    check("run_field", Field_sel, 0);

    // HOUR: single Up press, then Blink toggles on a tick with Sec_tick held off
    tick_en = 0;
    repeat (3) @(negedge Clk);
    exp_run = 0;
    mode_pulse();
    repeat (4) @(negedge Clk);
    check("hour_field", Field_sel, 1);
    check("hour_blink_entry", Blink, 0);
    n = cyc; push_adj(n + 4, A_HADD);
    Up_key = 1'b1; @(negedge Clk); Up_key = 1'b0;
    repeat (8) @(negedge Clk);
    tick_en = 1; repeat (10) @(negedge Clk); tick_en = 0;
    repeat (2) @(negedge Clk);
    check("hour_blink_toggle", Blink, 1);

    // MIN: Down held 20 cycles gives first pulse then repeats at +8, +12, +16
    n = cyc; mode_pulse(); wait_until(n + 5);
    check("min_field", Field_sel, 2);
    check("min_blink_entry", Blink, 0);
    n = cyc;
    push_adj(n + 4, A_MSUB); push_adj(n + 12, A_MSUB);
    push_adj(n + 16, A_MSUB); push_adj(n + 20, A_MSUB);
    Down_key = 1'b1; repeat (20) @(negedge Clk); Down_key = 1'b0;
    repeat (12) @(negedge Clk);

    // SEC: simultaneous Up/Down, then Down released first -> nothing; fresh edges pulse
    n = cyc; mode_pulse(); wait_until(n + 5);
    check("sec_field", Field_sel, 3);
    Up_key = 1'b1; Down_key = 1'b1;
    repeat (10) @(negedge Clk); Down_key = 1'b0;
    repeat (20) @(negedge Clk); Up_key = 1'b0;
    repeat (6) @(negedge Clk);
    check("sec_field_hold", Field_sel, 3);
    n = cyc; push_adj(n + 4, A_SADD);
    Up_key = 1'b1; @(negedge Clk); Up_key = 1'b0;
    repeat (6) @(negedge Clk);
    n = cyc; push_adj(n + 4, A_SSUB);
    Down_key = 1'b1; @(negedge Clk); Down_key = 1'b0;
    repeat (6) @(negedge Clk);
    n = cyc; mode_pulse(); wait_until(n + 5);
    check("wrap_to_run", Field_sel, 0);
    Up_key = 1'b1; @(negedge Clk); Up_key = 1'b0;
    repeat (8) @(negedge Clk);

    // HOUR idle timeout: 100 cycles after entry falls back to RUN
    n = cyc; mode_pulse(); wait_until(n + 5);
    check("to_field_entry", Field_sel, 1);
    tick_en = 1; wait_until(n + 95); tick_en = 0;
    wait_until(n + 100);
    check("to_blink_before", Blink, 1);
    wait_until(n + 103);
    check("to_field_last", Field_sel, 1);
    wait_until(n + 104);
    check("to_field_run", Field_sel, 0);
    check("to_blink_run", Blink, 0);
    exp_run = 1; tick_en = 1;
    repeat (25) @(negedge Clk);
    tick_en = 0;
    repeat (3) @(negedge Clk);
    exp_run = 0;

    // Up held in HOUR, Mode mid-repeat, then reset while in MIN
    n = cyc; mode_pulse(); wait_until(n + 5);
    check("abort_field_hour", Field_sel, 1);
    n = cyc;
    push_adj(n + 4, A_HADD); push_adj(n + 12, A_HADD); push_adj(n + 16, A_HADD);
    Up_key = 1'b1;
    wait_until(n + 14);
    mode_pulse();
    wait_until(n + 22);
    check("abort_field_min", Field_sel, 2);
    wait_until(n + 30);
    Reset_N = 1'b0;
    #1;
    check("abort_reset_field", Field_sel, 0);
    check("abort_reset_outs", {Sec_tick, adj, Blink}, 0);
    Up_key = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_N = 1'b1;
    repeat (6) @(negedge Clk);
    check("adjust_queue_empty", adj_q.size(), 0);
    check("tick_queue_empty", tick_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
